// File: rtl/viterbi_pkg.sv
// ---------------------------------------------------------------------------
// viterbi_pkg
// Shared types and helpers for the rate-1/2, K=3 (g0=7, g1=5 octal) Viterbi
// decoder: trellis constants, the trellis state type, the FSM encoding, the
// expected-symbol function of the code and a 2-bit Hamming distance helper.
// ---------------------------------------------------------------------------
package viterbi_pkg;

    localparam int K       = 3;
    localparam int NSTATES = 4;

    // Trellis state {u[n-1], u[n-2]}
    typedef logic [1:0] state_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fsm_t;

    // Code symbol {c0, c1} produced when input bit u is shifted into state s
    function automatic logic [1:0] exp_sym(input state_t s, input logic u);
        return {u ^ s[1] ^ s[0], u ^ s[0]};
    endfunction

    // Number of differing bits between two 2-bit symbols (0..2)
    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// ---------------------------------------------------------------------------
// viterbi_acs
// One add-compare-select cell. Adds each predecessor's path metric to its
// branch metric and keeps the smaller sum. On a tie the first predecessor
// (i_pm0, the {a,0} state) wins.
// Ports:
//   i_pm0, i_pm1  path metrics of the two predecessor states
//   i_bm0, i_bm1  branch metrics (0..2) of the two incoming branches
//   o_pm          selected (un-normalised) new path metric
//   o_dec         decision: 1 when predecessor 1 was chosen
// ---------------------------------------------------------------------------
module viterbi_acs #(
    parameter int METRIC_W = 6
) (
    input  logic [METRIC_W-1:0] i_pm0,
    input  logic [METRIC_W-1:0] i_pm1,
    input  logic [1:0]          i_bm0,
    input  logic [1:0]          i_bm1,
    output logic [METRIC_W-1:0] o_pm,
    output logic                o_dec
);

    logic [METRIC_W-1:0] w_cand0;
    logic [METRIC_W-1:0] w_cand1;

    // Metric spread stays small and the normaliser keeps values well below
    // the top of the range, so a same-width sum cannot wrap.
    assign w_cand0 = i_pm0 + {{(METRIC_W-2){1'b0}}, i_bm0};
    assign w_cand1 = i_pm1 + {{(METRIC_W-2){1'b0}}, i_bm1};

    assign o_dec = (w_cand1 < w_cand0);
    assign o_pm  = o_dec ? w_cand1 : w_cand0;

endmodule

// File: rtl/viterbi_decoder.sv
// ---------------------------------------------------------------------------
// viterbi_decoder
// Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code
// (g0=7, g1=5). Four ACS cells, register-exchange survivors of TB_DEPTH bits,
// decisions taken from the best state once the survivors are full, and a
// flush of state 0's survivor when a tail-terminated block ends.
//
// Ports:
//   clock      system clock, all logic on posedge
//   reset      synchronous active-high reset
//   in_valid   in_sym valid
//   in_ready   decoder can accept a symbol (RUN state, not in reset)
//   in_sym     code symbol {c0, c1}
//   in_last    final symbol of a tail-terminated block
//   out_valid  single-cycle pulse qualifying out_bit
//   out_bit    decoded data bit
//   out_last   final decoded bit of a block
//
// FSM:
//   state | meaning
//   RUN   | accepting symbols, emitting one bit per symbol once survivors are full
//   FLUSH | draining the pending bits of state 0's survivor, input stalled
// ---------------------------------------------------------------------------
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 16,
    parameter int METRIC_W = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_sym,
    input  logic       in_last,
    output logic       out_valid,
    output logic       out_bit,
    output logic       out_last
);

    localparam int                  PW      = $clog2(TB_DEPTH);
    localparam logic [PW-1:0]       P_LAST  = PW'(TB_DEPTH - 1);
    localparam logic [PW-1:0]       P_ONE   = PW'(1);
    localparam logic [METRIC_W-1:0] PM_INIT = METRIC_W'(1 << (METRIC_W - 2));

    // Registers
    fsm_t                r_state;
    logic [METRIC_W-1:0] r_pm   [NSTATES];
    logic [TB_DEPTH-1:0] r_surv [NSTATES];
    logic [PW-1:0]       r_p;
    logic                r_out_valid;
    logic                r_out_bit;
    logic                r_out_last;

    // Combinational
    fsm_t                w_state_nxt;
    logic                w_accept;
    logic [1:0]          w_bm0      [NSTATES];
    logic [1:0]          w_bm1      [NSTATES];
    logic [METRIC_W-1:0] w_pm_acs   [NSTATES];
    logic [METRIC_W-1:0] w_pm_new   [NSTATES];
    logic                w_dec      [NSTATES];
    logic [TB_DEPTH-1:0] w_surv_sel [NSTATES];
    logic [TB_DEPTH-1:0] w_surv_new [NSTATES];
    logic                w_norm;
    state_t              w_best;
    logic [METRIC_W-1:0] w_best_pm;

    // -----------------------------------------------------------------------
    // Trellis: next state {u,a} is reached from {a,0} and {a,1} with input u
    // -----------------------------------------------------------------------
    for (genvar n = 0; n < NSTATES; n++) begin : g_acs
        localparam logic   U  = (n >= 2);
        localparam logic   A  = ((n % 2) == 1);
        localparam state_t P0 = {A, 1'b0};
        localparam state_t P1 = {A, 1'b1};

        assign w_bm0[n] = hamming2(in_sym, exp_sym(P0, U));
        assign w_bm1[n] = hamming2(in_sym, exp_sym(P1, U));

        viterbi_acs #(
            .METRIC_W (METRIC_W)
        ) u_acs (
            .i_pm0 (r_pm[P0]),
            .i_pm1 (r_pm[P1]),
            .i_bm0 (w_bm0[n]),
            .i_bm1 (w_bm1[n]),
            .o_pm  (w_pm_acs[n]),
            .o_dec (w_dec[n])
        );

        assign w_surv_sel[n] = w_dec[n] ? r_surv[P1] : r_surv[P0];
        assign w_surv_new[n] = {w_surv_sel[n][TB_DEPTH-2:0], U};

        // Subtracting half range from every metric at once keeps ordering
        assign w_pm_new[n] = w_norm ? {1'b0, w_pm_acs[n][METRIC_W-2:0]} : w_pm_acs[n];
    end

    assign w_norm = w_pm_acs[0][METRIC_W-1] & w_pm_acs[1][METRIC_W-1] &
                    w_pm_acs[2][METRIC_W-1] & w_pm_acs[3][METRIC_W-1];

    // Best state on the post-ACS metrics; strict compare favours the lowest index
    always_comb begin
        w_best    = '0;
        w_best_pm = w_pm_new[0];
        for (int i = 1; i < NSTATES; i++) begin
            if (w_pm_new[i] < w_best_pm) begin
                w_best    = state_t'(i);
                w_best_pm = w_pm_new[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_accept && in_last) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (r_p == P_ONE) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // in_ready is gated by reset directly so it is low while reset is held
    always_comb begin
        in_ready = 1'b0;
        if ((r_state == RUN) && !reset) begin
            in_ready = 1'b1;
        end
        w_accept = in_valid && in_ready;
    end

    // -----------------------------------------------------------------------
    // Datapath: metrics, survivors, pending count, output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NSTATES; i++) begin
                r_pm[i]   <= (i == 0) ? '0 : PM_INIT;
                r_surv[i] <= '0;
            end
            r_p         <= '0;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
            case (r_state)
                RUN: begin
                    if (w_accept) begin
                        for (int i = 0; i < NSTATES; i++) begin
                            r_pm[i]   <= w_pm_new[i];
                            r_surv[i] <= w_surv_new[i];
                        end
                        if (r_p == P_LAST) begin
                            r_out_valid <= 1'b1;
                            r_out_bit   <= w_surv_new[w_best][TB_DEPTH-1];
                        end else begin
                            r_p <= r_p + P_ONE;
                        end
                    end
                end
                FLUSH: begin
                    // Tail termination forces the true path into state 0
                    r_out_valid <= 1'b1;
                    r_out_bit   <= r_surv[0][r_p - P_ONE];
                    r_p         <= r_p - P_ONE;
                    if (r_p == P_ONE) begin
                        r_out_last <= 1'b1;
                        for (int i = 0; i < NSTATES; i++) begin
                            r_pm[i]   <= (i == 0) ? '0 : PM_INIT;
                            r_surv[i] <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_bit   = r_out_bit;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_viterbi_decoder.sv
// ---------------------------------------------------------------------------
// tb_viterbi_decoder
// Randomised scoreboard bench. Stimulus encodes data blocks with the K=3
// (7,5) code, optionally corrupting symbols, and records the data bits. An
// observer turns each accepted symbol into timed expectations (bit, last,
// cycle) and a monitor pops and compares them whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_viterbi_decoder;

    localparam int TB_DEPTH = 16;
    localparam int METRIC_W = 6;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_sym   = 2'b00;
    logic       in_last  = 1'b0;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;

    viterbi_decoder #(
        .TB_DEPTH (TB_DEPTH),
        .METRIC_W (METRIC_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit b;
        bit last;
        int due;
    } exp_t;

    int   n_checks   = 0;
    int   n_pass     = 0;
    int   cyc        = 0;
    int   n_out      = 0;
    int   blk_n      = 0;
    int   max_spread = 0;
    bit   exp_flush  = 1'b0;
    exp_t sb[$];
    bit   model_bits[$];
    bit   tx_bits[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic bit bit_at(input int k);
        return (k < model_bits.size()) ? model_bits[k] : 1'b0;
    endfunction

    // -----------------------------------------------------------------------
    // Observer: converts accepted symbols into timed expectations
    // -----------------------------------------------------------------------
    int   obs_i;
    int   obs_run;
    int   sp_mn;
    int   sp_mx;
    exp_t obs_e;

    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            blk_n     = 0;
            exp_flush = 1'b0;
        end else begin
            if (blk_n >= 2) begin
                sp_mn = int'(dut.r_pm[0]);
                sp_mx = sp_mn;
                for (int k = 1; k < 4; k++) begin
                    if (int'(dut.r_pm[k]) < sp_mn) sp_mn = int'(dut.r_pm[k]);
                    if (int'(dut.r_pm[k]) > sp_mx) sp_mx = int'(dut.r_pm[k]);
                end
                if (sp_mx - sp_mn > max_spread) max_spread = sp_mx - sp_mn;
            end
            if (exp_flush && !out_last) chk("in_ready_flush", int'(in_ready), 0);
            if (out_last) exp_flush = 1'b0;
            if (in_valid && in_ready) begin
                obs_i = blk_n;
                if (obs_i >= TB_DEPTH - 1) begin
                    obs_e.b    = bit_at(obs_i - (TB_DEPTH - 1));
                    obs_e.last = 1'b0;
                    obs_e.due  = cyc + 1;
                    sb.push_back(obs_e);
                end
                blk_n++;
                if (in_last) begin
                    obs_run = (blk_n > TB_DEPTH - 1) ? blk_n - (TB_DEPTH - 1) : 0;
                    for (int j = obs_run; j < blk_n; j++) begin
                        obs_e.b    = bit_at(j);
                        obs_e.last = (j == blk_n - 1);
                        obs_e.due  = cyc + 2 + (j - obs_run);
                        sb.push_back(obs_e);
                    end
                    for (int j = 0; j < blk_n; j++) begin
                        if (model_bits.size() > 0) void'(model_bits.pop_front());
                    end
                    blk_n     = 0;
                    exp_flush = 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Monitor: pops and compares on every out_valid
    // -----------------------------------------------------------------------
    exp_t mon_e;

    always @(negedge clock) begin
        if (!reset && out_valid) begin
            n_out++;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out: out_valid with no pending bit, out_bit=%0d cycle %0d", out_bit, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("out_bit",  int'(out_bit),  int'(mon_e.b));
                chk("out_last", int'(out_last), int'(mon_e.last));
                chk("out_time", cyc,            mon_e.due);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_bits.delete();
        repeat (n) tick();
        chk("ready_in_reset", int'(in_ready),  0);
        chk("valid_in_reset", int'(out_valid), 0);
        chk("bit_in_reset",   int'(out_bit),   0);
        chk("last_in_reset",  int'(out_last),  0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", int'(in_ready), 1);
    endtask

    task automatic send_sym(input logic [1:0] s, input bit last, input bit gaps);
        int t;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        in_valid = 1'b1;
        in_sym   = s;
        in_last  = last;
        t = 0;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready stayed %0d for %0d cycles, required 1", in_ready, t);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Encode tx_bits from the zero state and send them; err_off>=0 flips one
    // code bit in every 8th symbol, cor_idx adds one deliberate corruption.
    task automatic run_block(input bit term, input int err_off, input int cor_idx,
                             input logic [1:0] cor_mask, input bit gaps, input bit hold);
        bit         d1;
        bit         d2;
        bit         u;
        logic [1:0] sym;
        int         nsym;
        int         t;
        d1   = 1'b0;
        d2   = 1'b0;
        nsym = tx_bits.size();
        foreach (tx_bits[i]) model_bits.push_back(tx_bits[i]);
        for (int i = 0; i < nsym; i++) begin
            u   = tx_bits[i];
            sym = {u ^ d1 ^ d2, u ^ d2};
            d2  = d1;
            d1  = u;
            if (err_off >= 0 && (i % 8) == err_off)
                sym = sym ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
            if (i == cor_idx) sym = sym ^ cor_mask;
            send_sym(sym, term && (i == nsym - 1), gaps);
        end
        if (term) begin
            if (hold) begin
                in_valid = 1'b1;
                in_sym   = 2'($urandom);
                in_last  = 1'($urandom);
                t = 0;
                while (!out_last && t < 100) begin
                    tick();
                    t++;
                end
                in_valid = 1'b0;
                in_last  = 1'b0;
                if (t >= 100) begin
                    n_checks++;
                    $display("FAIL flush_timeout: out_last not seen within %0d cycles, required 1", t);
                end
            end
            t = 0;
            while ((sb.size() != 0 || exp_flush) && t < 200) begin
                tick();
                t++;
            end
            chk("block_drained", sb.size(), 0);
        end
    endtask

    task automatic gen_lfsr(input int n);
        logic [15:0] r;
        bit          fb;
        r = 16'($urandom) | 16'h0001;
        tx_bits.delete();
        for (int i = 0; i < n; i++) begin
            tx_bits.push_back(r[15]);
            fb = r[15] ^ r[13] ^ r[12] ^ r[10];
            r  = {r[14:0], fb};
        end
        tx_bits.push_back(1'b0);
        tx_bits.push_back(1'b0);
    endtask

    task automatic load_case2();
        tx_bits.delete();
        tx_bits.push_back(1'b1);
        tx_bits.push_back(1'b0);
        tx_bits.push_back(1'b1);
        tx_bits.push_back(1'b1);
        tx_bits.push_back(1'b0);
        tx_bits.push_back(1'b0);
    endtask

    initial begin
        int base;
        int len;

        do_reset(2);

        // 1: 20 zero symbols, no termination -> 5 zero bits
        tx_bits.delete();
        repeat (20) tx_bits.push_back(1'b0);
        base = n_out;
        run_block(1'b0, -1, -1, 2'b00, 1'b0, 1'b0);
        repeat (4) tick();
        chk("t1_out_count", n_out - base, 5);
        chk("t1_pending", sb.size(), 0);
        do_reset(1);

        // 2: short terminated block, all bits come out of the flush
        load_case2();
        base = n_out;
        run_block(1'b1, -1, -1, 2'b00, 1'b0, 1'b0);
        chk("t2_out_count", n_out - base, 6);

        // 3: same block with the 3rd symbol corrupted to 10
        load_case2();
        base = n_out;
        run_block(1'b1, -1, 2, 2'b10, 1'b0, 1'b0);
        chk("t3_out_count", n_out - base, 6);

        // 4: 300-symbol LFSR block, one channel error per 8 symbols
        gen_lfsr(298);
        base = n_out;
        run_block(1'b1, int'($urandom_range(0, 7)), -1, 2'b00, 1'b0, 1'b0);
        chk("t4_out_count", n_out - base, 300);

        // 5: reset mid-block, no stale output, then a clean case 2
        gen_lfsr(298);
        while (tx_bits.size() > 10) void'(tx_bits.pop_back());
        run_block(1'b0, -1, -1, 2'b00, 1'b0, 1'b0);
        base = n_out;
        do_reset(1);
        repeat (20) tick();
        chk("t5_no_stale", n_out - base, 0);
        load_case2();
        run_block(1'b1, -1, -1, 2'b00, 1'b0, 1'b0);
        chk("t5_case2_count", n_out - base, 6);

        // 6: random gaps in RUN, in_valid held high through FLUSH
        for (int b = 0; b < 3; b++) begin
            len = int'($urandom_range(3, 40));
            gen_lfsr(len);
            base = n_out;
            run_block(1'b1, int'($urandom_range(0, 7)), -1, 2'b00, 1'b1, 1'b1);
            chk("t6_out_count", n_out - base, len + 2);
        end

        repeat (5) tick();
        chk("final_pending", sb.size(), 0);
        chk("pm_spread_le_4", (max_spread <= 4) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
